// File: rtl/uart_stream_pkg.sv
// Shared types and defaults for the memory-to-UART streaming controller.
package uart_stream_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned MEM_LAT_MAX = 4;
  // Wide enough to count 0..MEM_LAT_MAX-1 read-latency cycles.
  localparam int unsigned LAT_CNT_W   = $clog2(MEM_LAT_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StLat,
    StWaitTx,
    StSend,
    StAckHi,
    StAckLo,
    StFin
  } state_e;

endpackage

// File: rtl/stream_addr_gen.sv
// Window address generator: captures base/length, walks the byte offset and
// counts bytes handed to the UART.
module stream_addr_gen
  import uart_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              last,
  output logic [ADDR_W:0]   byte_cnt
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] offset_q;
  logic [ADDR_W:0]   cnt_q;
  logic              last_q;

  // Window registers: clear wins over load, load over advance.
  always_ff @(posedge clk) begin
    if (clear) begin
      base_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
    end else if (load) begin
      base_q   <= base_addr;
      len_q    <= len_m1;
      offset_q <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
    end else if (advance) begin
      // last_q marks that the byte just written was the final one of the window.
      last_q   <= (offset_q == len_q);
      offset_q <= offset_q + 1'b1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Address wraps silently modulo 2^ADDR_W.
  assign mem_addr = base_q + offset_q;
  assign last     = last_q;
  assign byte_cnt = cnt_q;

endmodule

// File: rtl/uart_stream_ctrl.sv
// Streams a programmable window of memory bytes to a UART transmitter using
// its busy handshake, with abort and done/aborted completion pulses.
module uart_stream_ctrl
  import uart_stream_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   byte_cnt
);

  state_e               state_q, state_d;
  logic                 abort_q;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic                 done_q;
  logic                 aborted_q;
  logic                 load;
  logic                 advance;
  logic                 last;
  logic                 lat_done;
  logic                 capture;

  assign lat_done = (lat_cnt_q == LAT_CNT_W'(MEM_LAT - 1));
  assign load     = (state_q == StIdle) && start;
  assign advance  = (state_q == StSend);
  assign capture  = (state_q == StLat) && lat_done && !abort_q;

  stream_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .clear     (~rst_n),
    .load      (load),
    .advance   (advance),
    .base_addr (base_addr),
    .len_m1    (len_m1),
    .mem_addr  (mem_addr),
    .last      (last),
    .byte_cnt  (byte_cnt)
  );

  // State, abort latch, latency counter, output byte and completion pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      abort_q   <= 1'b0;
      lat_cnt_q <= '0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Abort seen alongside an accepted start is dropped: start wins.
      abort_q   <= (state_q == StIdle) ? 1'b0 : (abort_q | abort);
      lat_cnt_q <= (state_q == StLat) ? lat_cnt_q + 1'b1 : '0;
      if (capture) begin
        tx_data_q <= mem_rdata;
      end
      // A stream whose final byte completed reports done even if abort arrived too.
      done_q    <= (state_q == StFin) && last;
      aborted_q <= (state_q == StFin) && !last;
    end
  end

  // Next-state logic for the per-byte read/send/handshake sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRd;
      StRd:     state_d = abort_q ? StFin : StLat;
      StLat: begin
        if (abort_q) begin
          state_d = StFin;
        end else if (lat_done) begin
          // Skip the wait state when the UART is already free.
          state_d = tx_busy ? StWaitTx : StSend;
        end
      end
      StWaitTx: begin
        if (abort_q) begin
          state_d = StFin;
        end else if (!tx_busy) begin
          state_d = StSend;
        end
      end
      StSend:   state_d = StAckHi;
      StAckHi:  if (tx_busy) state_d = StAckLo;
      StAckLo:  if (!tx_busy) state_d = (last || abort_q) ? StFin : StRd;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign mem_rd_en = (state_q == StRd);
  assign tx_wr_en  = (state_q == StSend);
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule
